// File: rtl/pulse_train_generator.sv
// Pulse train generator.
// On a start request in IDLE, emits `count` high pulses of `width` cycles,
// separated by `gap` low cycles, on a registered `pulse` output.
// width/gap of 0 are promoted to 1; count of 0 produces only a done strobe.
//
// Handshake: there is no valid/ready pair. `start` is a request that is only
// sampled while IDLE (including the cycle in which done=1); it is ignored
// while a train is running. `abort` is a synchronous cancel that wins over
// `start` and never produces `done`.
//
// state_o exposes the FSM state (0=IDLE, 1=HIGH, 2=LOW) for debug/checkers.
module pulse_train_generator #(
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH_W-1:0] width,
  input  logic [WIDTH_W-1:0] gap,
  input  logic [COUNT_W-1:0] count,
  output logic               pulse,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [WIDTH_W-1:0] W_ZERO = '0;
  localparam logic [WIDTH_W-1:0] W_ONE  = {{(WIDTH_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] C_ZERO = '0;
  localparam logic [COUNT_W-1:0] C_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  // Remaining cycles in the current phase after the present one.
  logic [WIDTH_W-1:0] phase_q, phase_d;
  // Pulses still to be emitted, including the one currently high.
  logic [COUNT_W-1:0] pulses_q, pulses_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [WIDTH_W-1:0] gap_q, gap_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Promoted request parameters (0 treated as 1).
  logic [WIDTH_W-1:0] width_eff;
  logic [WIDTH_W-1:0] gap_eff;

  assign width_eff = (width == W_ZERO) ? W_ONE : width;
  assign gap_eff   = (gap   == W_ZERO) ? W_ONE : gap;

  // State, counters, latched parameters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      pulses_q <= '0;
      width_q  <= '0;
      gap_q    <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pulses_q <= pulses_d;
      width_q  <= width_d;
      gap_q    <= gap_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; outputs default low every cycle.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pulses_d = pulses_q;
    width_d  = width_q;
    gap_d    = gap_q;
    pulse_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (count != C_ZERO) begin
            width_d  = width_eff;
            gap_d    = gap_eff;
            pulses_d = count;
            phase_d  = width_eff - W_ONE;
            state_d  = ST_HIGH;
            pulse_d  = 1'b1;
            busy_d   = 1'b1;
          end else begin
            // Empty train: completion strobe only.
            done_d = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (abort) begin
          state_d  = ST_IDLE;
          phase_d  = '0;
          pulses_d = '0;
        end else if (phase_q == W_ZERO) begin
          if (pulses_q > C_ONE) begin
            state_d  = ST_LOW;
            phase_d  = gap_q - W_ONE;
            pulses_d = pulses_q - C_ONE;
            busy_d   = 1'b1;
          end else begin
            // Last pulse finished; done cycle doubles as minimum low gap.
            state_d  = ST_IDLE;
            phase_d  = '0;
            pulses_d = '0;
            done_d   = 1'b1;
          end
        end else begin
          phase_d = phase_q - W_ONE;
          pulse_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_LOW: begin
        if (abort) begin
          state_d  = ST_IDLE;
          phase_d  = '0;
          pulses_d = '0;
        end else if (phase_q == W_ZERO) begin
          state_d = ST_HIGH;
          phase_d = width_q - W_ONE;
          pulse_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          phase_d = phase_q - W_ONE;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        phase_d  = '0;
        pulses_d = '0;
      end
    endcase
  end

  assign pulse   = pulse_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed testbench for pulse_train_generator.
module tb_pulse_train_generator;

  localparam int WIDTH_W = 8;
  localparam int COUNT_W = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [WIDTH_W-1:0] width;
  logic [WIDTH_W-1:0] gap;
  logic [COUNT_W-1:0] count;
  logic               pulse;
  logic               busy;
  logic               done;
  logic [1:0]         state_o;

  int errors = 0;
  int checks = 0;

  // Expected pulse samples for the train under test.
  logic exp_q[$];

  pulse_train_generator #(
    .WIDTH_W(WIDTH_W),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .width  (width),
    .gap    (gap),
    .count  (count),
    .pulse  (pulse),
    .busy   (busy),
    .done   (done),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int w, input int g, input int c);
    width = WIDTH_W'(w);
    gap   = WIDTH_W'(g);
    count = COUNT_W'(c);
  endtask

  // Build the expected waveform for a train from promoted parameters.
  task automatic build_exp(input int w, input int g, input int c);
    int we;
    int ge;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    exp_q.delete();
    for (int p = 0; p < c; p++) begin
      for (int i = 0; i < we; i++) exp_q.push_back(1'b1);
      if (p != c - 1)
        for (int i = 0; i < ge; i++) exp_q.push_back(1'b0);
    end
  endtask

  // Start a train, compare every sample against exp_q, then check the
  // done cycle. Also counts rising edges and isolated one-cycle pulses as a
  // loopback edge detector / one-cycle pulse detector would.
  task automatic run_train(input string tag, input int w, input int g, input int c,
                           input int exp_edges, input int exp_ones);
    logic p0, p1, p2;
    int   edges, ones, n;
    build_exp(w, g, c);
    n = exp_q.size();
    p1 = 1'b0; p2 = 1'b0; edges = 0; ones = 0;
    set_req(w, g, c);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= n; i++) begin
      p0 = pulse;
      if (i < n) begin
        check({tag, " pulse"}, int'(pulse), int'(exp_q[i]));
        check({tag, " busy"}, int'(busy), 1);
        check({tag, " done_low"}, int'(done), 0);
      end else begin
        check({tag, " end_pulse"}, int'(pulse), 0);
        check({tag, " end_busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 1);
      end
      if (p0 && !p1) edges++;
      if (!p0 && p1 && !p2) ones++;
      p2 = p1;
      p1 = p0;
      if (i < n) tick();
    end
    check({tag, " edges"}, edges, exp_edges);
    if (exp_ones >= 0) check({tag, " one_cycle"}, ones, exp_ones);
    tick();
    check({tag, " done_one_cycle"}, int'(done), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hi_cycles;
    int npulses;
    int cyc;
    logic prev;

    start = 1'b0;
    abort = 1'b0;
    set_req(0, 0, 0);
    rst = 1'b1;
    #12;
    check("reset pulse", int'(pulse), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset state", int'(state_o), 0);
    rst = 1'b0;
    tick();
    check("idle pulse", int'(pulse), 0);

    // Basic trains.
    run_train("w1g1c3", 1, 1, 3, 3, 3);
    tick();
    run_train("w3g2c2", 3, 2, 2, 2, 0);
    tick();
    run_train("w0g0c2", 0, 0, 2, 2, 2);
    tick();

    // Empty train: done only.
    set_req(5, 5, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c0 pulse", int'(pulse), 0);
    check("c0 busy", int'(busy), 0);
    check("c0 done", int'(done), 1);
    tick();
    check("c0 done_one_cycle", int'(done), 0);
    check("c0 busy_after", int'(busy), 0);

    // Abort and start-during-train with frozen parameters.
    build_exp(4, 4, 5);
    set_req(4, 4, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("frz pulse", int'(pulse), int'(exp_q[i]));
      check("frz busy", int'(busy), 1);
      if (i == 1) begin
        start = 1'b1;
        set_req(1, 1, 1);
      end
      if (i == 3) start = 1'b0;
      if (i == 13) abort = 1'b1;   // second cycle of the 2nd LOW phase
      tick();
    end
    abort = 1'b0;
    check("abort pulse", int'(pulse), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort state", int'(state_o), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort no_done", int'(done), 0);
      check("abort stay_low", int'(pulse), 0);
    end
    run_train("w4g4c5", 4, 4, 5, 5, 0);

    // Abort in the same cycle as start: abort wins.
    set_req(2, 2, 2);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start pulse", int'(pulse), 0);
    check("abort_start busy", int'(busy), 0);
    check("abort_start done", int'(done), 0);

    // Back-to-back: start in the done cycle.
    set_req(2, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b a0", int'(pulse), 1);
    tick();
    check("b2b a1", int'(pulse), 1);
    tick();
    check("b2b a_gap", int'(pulse), 0);
    check("b2b a_done", int'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b b0", int'(pulse), 1);
    check("b2b b0_busy", int'(busy), 1);
    check("b2b b0_done", int'(done), 0);
    tick();
    check("b2b b1", int'(pulse), 1);
    tick();
    check("b2b b_end", int'(pulse), 0);
    check("b2b b_done", int'(done), 1);
    tick();
    check("b2b b_done_one", int'(done), 0);

    // Maximum width: exactly 255 high cycles.
    set_req(255, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    hi_cycles = 0;
    cyc = 0;
    while (!done && cyc < 400) begin
      if (pulse) hi_cycles++;
      tick();
      cyc++;
    end
    check("maxw timeout", int'(cyc < 400), 1);
    check("maxw high_cycles", hi_cycles, 255);

    // Maximum count: exactly 255 pulses.
    tick();
    set_req(1, 1, 255);
    start = 1'b1;
    tick();
    start = 1'b0;
    npulses = 0;
    prev = 1'b0;
    cyc = 0;
    while (!done && cyc < 800) begin
      if (pulse && !prev) npulses++;
      prev = pulse;
      tick();
      cyc++;
    end
    check("maxc timeout", int'(cyc < 800), 1);
    check("maxc pulses", npulses, 255);
    check("maxc cycles", cyc, 509);

    // Async reset in the middle of a HIGH phase.
    tick();
    set_req(4, 2, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst pre_pulse", int'(pulse), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst async_pulse", int'(pulse), 0);
    check("rst async_busy", int'(busy), 0);
    check("rst async_done", int'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    check("rst after_pulse", int'(pulse), 0);
    check("rst after_done", int'(done), 0);
    check("rst after_state", int'(state_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
- Generates the pulse patterns that the edge and one-cycle-pulse detectors consume.
- On a start request it emits a train of `count` high pulses, each `width` cycles long, separated by `gap` low cycles, on a single registered output.
- Serves as the stimulus/transmit side for pulse-detection paths and as a self-checking source when looped back into a pulse detector.

Parameters:
- WIDTH_W, 8, bit width of the width and gap fields (max phase length 2^WIDTH_W-1 cycles).
- COUNT_W, 8, bit width of the pulse-count field.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  synchronous cancel of the current train.
- width  input  WIDTH_W  high-phase length in cycles; 0 is treated as 1.
- gap  input  WIDTH_W  low-phase length between pulses; 0 is treated as 1.
- count  input  COUNT_W  number of pulses; 0 means an empty train.
- pulse  output  1  generated waveform, registered.
- busy  output  1  train in progress, registered.
- done  output  1  one-cycle completion strobe, registered.

Behaviour:
- Reset (async, any state): state=IDLE; pulse=0, busy=0, done=0; internal counters 0.
- States: IDLE, HIGH, LOW.
- IDLE:
  - start=1, abort=0, count!=0: latch width, gap, count (0 promoted to 1 for width/gap). Next cycle state=HIGH, pulse=1, busy=1.
  - start=1, abort=0, count==0: no pulse. done=1 for exactly one cycle next cycle; busy stays 0.
  - start=0 or abort=1: stay IDLE. abort wins over start in the same cycle.
- Latency: pulse rises on the first clock edge after start is sampled (1 cycle).
- HIGH: pulse=1 for exactly latched-width cycles.
  - At the end of the phase, remaining pulses > 1: go to LOW, pulse=0.
  - At the end of the last pulse: go to IDLE; pulse=0, busy=0, done=1 for one cycle.
- LOW: pulse=0 for exactly latched-gap cycles, then HIGH with pulse=1.
- busy=1 from the first HIGH cycle through the last HIGH cycle inclusive. Not asserted for count==0.
- done is not asserted on abort.
- Start while busy: ignored. Latched parameters are frozen for the whole train; input changes mid-train have no effect.
- Start in the same cycle done=1: accepted (state is IDLE). The done cycle is then the 1-cycle minimum low between trains. This guarantees adjacent pulses are always separated by at least one low cycle.
- abort in HIGH or LOW: next cycle state=IDLE, pulse=0, busy=0, done=0; counters cleared.
- Counters:
  - Phase counter: WIDTH_W bits, counts down, no wrap.
  - Pulse counter: COUNT_W bits, decremented at the end of each HIGH phase.
  - Max values (all ones) must produce exactly 2^N-1 cycles/pulses.
- Total train length in cycles = count*width + (count-1)*gap, using promoted values.
- rst asserted mid-train: outputs go to 0 immediately (async). No done.

Test Plan:
- width=1, gap=1, count=3, start pulse -> pulse from the next cycle = 1,0,1,0,1 then 0 with done=1. busy high for 5 cycles. A loopback one_cycle_pulse_detector flags 3 detections.
- width=3, gap=2, count=2 -> pulse = 1,1,1,0,0,1,1,1, then done. A loopback posedge_detector fires exactly twice.
- width=0, gap=0, count=2 -> identical to width=1, gap=1: 1,0,1 then done.
- count=0 start -> pulse stays 0, busy stays 0, done=1 exactly one cycle after start.
- Train width=4, gap=4, count=5:
  - start re-asserted mid-train -> ignored, train unchanged.
  - abort in the 2nd LOW phase -> pulse=0, busy=0 next cycle, done never asserted.
  - A new start then begins a fresh 5-pulse train.
- Back-to-back: start asserted in the done cycle (width=2, gap=1, count=1, twice) -> pulse = 1,1,0,1,1, and done asserted twice. Also: async rst mid-HIGH -> pulse=0 before the next edge.
